// File: rtl/rr_mux.sv
// Round-robin N:1 valid/ready multiplexer with a single registered output stage.
// out_sel carries the source lane so a downstream demux can route the word back.
module rr_mux #(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic            any_req;
  logic            load_en;
  logic            vld_p0;
  logic [W-1:0]    data_p0;
  logic [SELW-1:0] sel_p0;

  assign load_en = !vld_p0 || out_ready;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int              idx;
      logic [SELW-1:0] cand;
      idx  = (int'(ptr) + k) % N;
      cand = SELW'(idx);
      if (in_valid[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && any_req) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      ptr     <= SELW'(N - 1);
    end else if (load_en) begin
      if (any_req) begin
        vld_p0  <= 1'b1;
        data_p0 <= in_data[int'(grant)*W +: W];
        sel_p0  <= grant;
        ptr     <= grant;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_sel   = sel_p0;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a round-robin reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_rr_mux;
  localparam int N = 8;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_sel;

  int passed = 0;
  int total  = 0;

  // Reference model state: the word currently on the output and the last lane served.
  int m_vld  = 0;
  int m_data = 0;
  int m_sel  = 0;
  int m_last = N - 1;

  rr_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // First requesting lane strictly after 'last', wrapping; -1 when nobody asks.
  function automatic int next_lane(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int lane_data(input int i);
    return int'(in_data[i*W +: W]);
  endfunction

  function automatic int exp_ready();
    int g;
    if (!rst_n) return 0;
    if (!(m_vld == 0 || out_ready)) return 0;
    g = next_lane(m_last, in_valid);
    if (g < 0) return 0;
    return 1 << g;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_vld = 0; m_data = 0; m_sel = 0; m_last = N - 1;
    end else if (m_vld == 0 || out_ready) begin
      g = next_lane(m_last, in_valid);
      if (g >= 0) begin
        m_vld = 1; m_data = lane_data(g); m_sel = g; m_last = g;
      end else begin
        m_vld = 0;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    check("model in_ready", int'(in_ready), exp_ready());
    check("model out_valid", int'(out_valid), m_vld);
    check("model out_data", int'(out_data), m_data);
    check("model out_sel", int'(out_sel), m_sel);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic all_lanes();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
    in_valid = 8'hFF;
  endtask

  task automatic expect_out(input string name, input int v, input int d, input int s);
    check({name, " valid"}, int'(out_valid), v);
    check({name, " data"}, int'(out_data), d);
    check({name, " sel"}, int'(out_sel), s);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      tick(); #3;
      expect_out("idle", 0, 0, 0);
      check("idle in_ready", int'(in_ready), 0);
    end

    // Single source on lane 3
    in_valid = 8'h08; in_data[3*W +: W] = 8'hA5;
    #3 check("single in_ready first", int'(in_ready), 8'h08);
    for (int c = 0; c < 3; c++) begin
      tick(); #3;
      expect_out("single", 1, 8'hA5, 3);
      check("single in_ready", int'(in_ready), 8'h08);
    end

    // Restart from reset so the fairness sweep begins at lane 0
    rst_n = 1'b0; in_valid = '0;
    tick(); #3;
    expect_out("reset", 0, 0, 0);
    check("reset in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    all_lanes();
    #1 check("all first in_ready", int'(in_ready), 8'h01);
    for (int k = 0; k < 19; k++) begin
      tick(); #3;
      expect_out("rr sweep", 1, 8'h10 + (k % N), k % N);
    end

    // Backpressure while holding lane 2's word
    out_ready = 1'b0;
    #1 check("bp in_ready", int'(in_ready), 0);
    for (int c = 0; c < 4; c++) begin
      tick(); #3;
      expect_out("bp hold", 1, 8'h12, 2);
      check("bp hold in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", int'(in_ready), 8'h08);
    tick(); #3;
    expect_out("bp next", 1, 8'h13, 3);

    // Skip and wrap after lane 6
    in_valid = 8'h40;
    tick(); #3; expect_out("to lane6", 1, 8'h16, 6);
    in_valid = 8'h05;
    tick(); #3; expect_out("skip a", 1, 8'h10, 0);
    tick(); #3; expect_out("skip b", 1, 8'h12, 2);
    tick(); #3; expect_out("skip c", 1, 8'h10, 0);
    in_valid = 8'h40;
    tick(); #3; expect_out("to lane6 again", 1, 8'h16, 6);
    in_valid = 8'h81;
    #1 check("wrap in_ready", int'(in_ready), 8'h80);
    tick(); #3; expect_out("wrap 7", 1, 8'h17, 7);
    tick(); #3; expect_out("wrap 0", 1, 8'h10, 0);

    // Reset in the middle of an all-request stream
    all_lanes();
    for (int k = 1; k <= 5; k++) begin
      tick(); #3;
      expect_out("pre-reset", 1, 8'h10 + k, k);
    end
    rst_n = 1'b0;
    #1 check("mid reset in_ready", int'(in_ready), 0);
    tick(); #3;
    expect_out("mid reset", 0, 0, 0);
    check("mid reset in_ready held", int'(in_ready), 0);
    rst_n = 1'b1;
    #1 check("post reset in_ready", int'(in_ready), 8'h01);
    for (int k = 0; k < 3; k++) begin
      tick(); #3;
      expect_out("post reset", 1, 8'h10 + k, k);
    end

    in_valid = '0;
    tick(); tick(); #3;
    expect_out("drain", 0, 8'h12, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
Name: rr_mux

Overview:
- Collects N independent valid/ready input channels onto one registered output channel, which is the inverse of the 1-to-N demux.
- Arbitration is round-robin, so every requesting source is served within N grants.
- The output carries the data and the index of the source it came from. A downstream demux can use that index as its select to route the word back out.
- Sits between per-lane producers and a shared single-lane consumer.

Parameters:
- N, 8, number of input channels (2..32).
- W, 8, data width per channel.
- SELW, $clog2(N), width of the source index. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_ready  output  N  per-channel ready. Combinational; at most one bit is high.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- out_valid  output  1  output word valid (registered).
- out_ready  input  1  downstream accepts the word.
- out_data  output  W  registered data of the granted channel.
- out_sel  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset: one clock is synchronous and active-low. Any edge with rst_n=0 sets:
  - out_valid=0, out_data=0, out_sel=0;
  - round-robin pointer ptr=N-1, so the first search starts at channel 0.
- While rst_n=0, in_ready is forced to all-zero.
- Reset mid-transfer discards the held word; no handshake completes on that edge.
- Output stage is one register. load_en = !out_valid || out_ready.
- Grant: the first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... and wrapping modulo N. When ptr=N-1 the scan wraps to 0.
- in_ready[i] = rst_n && load_en && (grant==i) && in_valid[i]. It is one-hot or zero, and never high for an idle channel.
- Input transfer happens on an edge where in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i]; out_sel <= i; out_valid <= 1; ptr <= i.
- If load_en=1 and no in_valid bit is set: out_valid <= 0, and ptr, out_data and out_sel hold.
- If out_valid=1 and out_ready=0: out_valid, out_data and out_sel are stable, and all in_ready bits are 0 (backpressure).
- Simultaneous out_ready=1 and an input transfer on the same edge: the old word leaves and the new word loads. This gives full throughput of 1 word per cycle with no bubble.
- Latency: a word accepted on edge k is presented on out_* from edge k until it is accepted downstream.
- Fairness:
  - With all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
  - A single continuously requesting channel gets every cycle.
  - A channel that drops valid loses no position; the scan simply skips it.
- in_ready depends combinationally on in_valid and out_ready. No path from in_ready back to in_valid is permitted inside this block.
- in_data of non-granted channels is ignored.

Test Plan:
1. Reset, then in_valid=8'h00 for 5 cycles: out_valid=0, in_ready=0, out_sel=0, out_data=0 throughout.
2. Single source: in_valid=8'h08, in_data lane3=8'hA5, out_ready=1.
   - in_ready=8'h08 every cycle.
   - From the next edge, out_valid=1, out_data=A5, out_sel=3, and these hold each cycle.
3. All-request fairness: in_valid=8'hFF, lane i data=8'h10+i, out_ready=1, for 16 cycles.
   - out_sel sequence 0..7,0..7; out_data 10..17,10..17.
   - Throughput of 1 word per cycle.
4. Backpressure: with out_valid=1, out_sel=2, out_data=12, hold out_ready=0 for 4 cycles while in_valid=8'hFF.
   - Outputs stay stable and in_ready=0.
   - On release, the next grant is channel 3.
5. Skip/wrap: ptr=6 after granting lane 6, then in_valid=8'h05.
   - Grants go to lane 0, then lane 2, then lane 0 again.
   - Lane 7 is granted before lane 0 when in_valid=8'h81 after ptr=6.
6. Reset mid-stream during test 3 at cycle 5 (rst_n=0 for 1 cycle):
   - out_valid=0 on the following cycle.
   - The first grant after release is lane 0.
   - No data word is duplicated or lost across a completed handshake.
